hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core. Issues stall, bubble and flush

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_cmp.sv | 21 ++
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding and
// bit positions of the latch-control vector consumed by the pipeline latches.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int CTL_PC_EN        = 0;
  localparam int CTL_IF_ID_EN     = 1;
  localparam int CTL_IF_ID_FLUSH  = 2;
  localparam int CTL_ID_EX_EN     = 3;
  localparam int CTL_ID_EX_BUBBLE = 4;
  localparam int CTL_EX_MEM_EN    = 5;
  localparam int CTL_W            = 6;

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// Load-use comparator: flags an ID source register that a load currently in EX
// will write. Register 0 is hardwired and never produces a hit.
module hazard_cmp (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_to_reg,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_rt,
  output logic       load_use_hit
);

  logic rs_match;
  logic rt_match;

  assign rs_match     = (ex_rt == id_rs);
  assign rt_match     = id_uses_rt && (ex_rt == id_rt);
  assign load_use_hit = ex_mem_to_reg && ex_reg_write && (ex_rt != 5'd0) &&
                        (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/bubble/flush enables for PC, IF/ID, ID/EX
// and EX/MEM, covering dmem waits, taken-branch redirects and load-use hazards.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter  int MEM_TIMEOUT = 15,
  parameter  int CNT_W       = 16,
  localparam int WC_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_to_reg,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             state_o,
  output logic [WC_W-1:0]  wait_cnt_o
);

  localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

  // dmem handshake: mem_req marks an access in MEM this cycle; the access
  // completes in the cycle mem_ready is high. Until then the pipe freezes.
  state_e             state_q, state_d;
  logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CTL_W-1:0]   ctl;
  logic               load_use_hit;
  logic               freeze;

  hazard_cmp u_cmp (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_rt         (ex_rt),
    .load_use_hit  (load_use_hit)
  );

  assign freeze = mem_req && !mem_ready && (wait_cnt_q < TIMEOUT_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    ctl        = '0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    stall_d    = stall_q;

    if (rst) begin
      ctl = '0;
    end else if (freeze) begin
      wait_cnt_d = wait_cnt_q + WC_W'(1);
      state_d    = MEM_WAIT;
    end else begin
      ctl[CTL_PC_EN]     = 1'b1;
      ctl[CTL_IF_ID_EN]  = 1'b1;
      ctl[CTL_ID_EX_EN]  = 1'b1;
      ctl[CTL_EX_MEM_EN] = 1'b1;
      // A release with mem_ready still low can only be the forced timeout.
      if (state_q == MEM_WAIT && wait_cnt_q == TIMEOUT_V && !mem_ready) begin
        mem_err_d = 1'b1;
      end
      state_d    = RUN;
      wait_cnt_d = '0;
      if (branch_taken) begin
        ctl[CTL_IF_ID_FLUSH]  = 1'b1;
        ctl[CTL_ID_EX_BUBBLE] = 1'b1;
      end else if (load_use_hit) begin
        ctl[CTL_PC_EN]        = 1'b0;
        ctl[CTL_IF_ID_EN]     = 1'b0;
        ctl[CTL_ID_EX_BUBBLE] = 1'b1;
      end
    end

    if (!rst && !ctl[CTL_PC_EN] && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  assign pc_en        = ctl[CTL_PC_EN];
  assign if_id_en     = ctl[CTL_IF_ID_EN];
  assign if_id_flush  = ctl[CTL_IF_ID_FLUSH];
  assign id_ex_en     = ctl[CTL_ID_EX_EN];
  assign id_ex_bubble = ctl[CTL_ID_EX_BUBBLE];
  assign ex_mem_en    = ctl[CTL_EX_MEM_EN];
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;
  assign state_o      = state_q;
  assign wait_cnt_o   = wait_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int T  = 4;
  localparam int CW = 8;
  localparam int WW = 3;
  localparam int SW = 1 + WW + 1 + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rt = 1'b0, ex_mem_to_reg = 1'b0, ex_reg_write = 1'b0;
  logic          branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en;
  logic          mem_err, state_o;
  logic [CW-1:0] stall_cycles;
  logic [WW-1:0] wait_cnt_o;

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_rt         (ex_rt),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .if_id_flush   (if_id_flush),
    .id_ex_en      (id_ex_en),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_en     (ex_mem_en),
    .mem_err       (mem_err),
    .stall_cycles  (stall_cycles),
    .state_o       (state_o),
    .wait_cnt_o    (wait_cnt_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [SW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_wait  = 1'b0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;
  int m_stall = 0;
  logic [5:0] m_e;

  // Packing: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en}
  function automatic logic [5:0] model_ctl();
    bit lu;
    lu = ex_mem_to_reg && ex_reg_write && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (rst) return 6'b000000;
    if (mem_req && !mem_ready && (m_cnt < T)) return 6'b000000;
    if (branch_taken) return 6'b111111;
    if (lu) return 6'b000111;
    return 6'b110101;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_wait = 1'b0; m_cnt = 0; m_err = 1'b0; m_stall = 0;
    end else begin
      m_e = model_ctl();
      if (mem_req && !mem_ready && (m_cnt < T)) begin
        m_cnt++;
        m_wait = 1'b1;
      end else begin
        if (m_wait && (m_cnt == T) && !mem_ready) m_err = 1'b1;
        m_wait = 1'b0;
        m_cnt  = 0;
      end
      if (!m_e[5] && (m_stall < (1 << CW) - 1)) m_stall++;
    end
    exp_q.push_back({m_wait, WW'(m_cnt), m_err, CW'(m_stall)});
  end

  // ---------------- compare process ----------------
  logic [SW-1:0] e_reg;
  always @(negedge clk) begin
    #1;
    chk("ctl", {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en}, model_ctl());
    if (rst) begin
      exp_q.delete();
      chk("rst_state", state_o, 0);
      chk("rst_wait", wait_cnt_o, 0);
      chk("rst_err", mem_err, 0);
      chk("rst_stall", stall_cycles, 0);
    end else if (exp_q.size() > 0) begin
      e_reg = exp_q.pop_front();
      chk("state", state_o, e_reg[SW-1]);
      chk("wait_cnt", wait_cnt_o, e_reg[SW-2 -: WW]);
      chk("mem_err", mem_err, e_reg[CW]);
      chk("stall", stall_cycles, e_reg[CW-1:0]);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses, input logic ld, input logic rw,
                      input logic [4:0] xrt, input logic br, input logic req,
                      input logic rdy);
    @(negedge clk);
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_to_reg = ld;
    ex_reg_write = rw; ex_rt = xrt; branch_taken = br; mem_req = req; mem_ready = rdy;
    #2;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t0_pc_en", pc_en, 0);
      chk("t0_ex_mem_en", ex_mem_en, 0);
    end

    // Load-use on rs
    step(0, 5, 0, 0, 1, 1, 5, 0, 0, 0);
    chk("t1_pc_en", pc_en, 0);
    chk("t1_if_id_en", if_id_en, 0);
    chk("t1_bubble", id_ex_bubble, 1);
    chk("t1_ex_mem_en", ex_mem_en, 1);
    step(0, 5, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("t1_pc_after", pc_en, 1);
    chk("t1_stall", stall_cycles, 1);

    // Register 0 and unused rt field
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("t2_r0_pc", pc_en, 1);
    step(0, 3, 7, 0, 1, 1, 7, 0, 0, 0);
    chk("t2_rt_pc", pc_en, 1);
    chk("t2_rt_bubble", id_ex_bubble, 0);

    // Branch beats load-use
    step(0, 5, 0, 0, 1, 1, 5, 1, 0, 0);
    chk("t3_flush", if_id_flush, 1);
    chk("t3_bubble", id_ex_bubble, 1);
    chk("t3_pc", pc_en, 1);
    chk("t3_if_id_en", if_id_en, 1);
    idle();
    chk("t3_stall", stall_cycles, 1);

    // Memory wait of 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("t4_frz_en", {pc_en, if_id_en, id_ex_en, ex_mem_en}, 4'b0000);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("t4_rel_en", {pc_en, if_id_en, id_ex_en, ex_mem_en}, 4'b1111);
    idle();
    chk("t4_stall", stall_cycles, 4);
    chk("t4_state", state_o, 0);

    // Timeout after T frozen cycles
    for (int i = 0; i < T; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("t5_frz_pc", pc_en, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t5_rel_pc", pc_en, 1);
    chk("t5_wait", wait_cnt_o, T);
    chk("t5_state", state_o, 1);
    idle();
    chk("t5_err", mem_err, 1);
    chk("t5_stall", stall_cycles, 8);
    idle();
    chk("t5_err_sticky", mem_err, 1);

    // Reset in the middle of a wait
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t6_state_pre", state_o, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t6_rst_pc", pc_en, 0);
    chk("t6_rst_flush", if_id_flush, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("t6_state", state_o, 0);
    chk("t6_wait", wait_cnt_o, 0);
    chk("t6_err", mem_err, 0);
    chk("t6_stall", stall_cycles, 0);
    chk("t6_pc", pc_en, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 999) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 30));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
